// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched, masked, fixed-priority interrupt sequencer.
// Optional internal timer source enabled by `define TIMER_IRQ_EN.
module intr_ctrl #(
  parameter int              NSRC         = 4,
  parameter int              PC_W         = 10,
  parameter logic [PC_W-1:0] VEC_BASE     = 10'h3C0,
  parameter int              VEC_STRIDE   = 8,
  parameter int              TIMER_PERIOD = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            we_mask,
  input  logic [7:0]      mask_in,
  input  logic            int_ack,
  input  logic            s_finish_interr,
  output logic            s_interruption,
  output logic [PC_W-1:0] int_vector,
  output logic [2:0]      int_id,
  output logic [7:0]      pending,
  output logic            busy
);

`ifdef TIMER_IRQ_EN
  localparam int NS = NSRC + 1;
`else
  localparam int NS = NSRC;
`endif

  localparam logic [7:0] SRC_MASK =
    8'((9'd1 << NS) - 9'd1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state, state_n;

  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] rise;

  logic [7:0] pend_q;
  logic [7:0] mask_q;
  logic [7:0] set_v;
  logic [7:0] clr_v;
  logic [7:0] req_v;

  logic [2:0]      sel_id;
  logic [PC_W-1:0] sel_vec;
  logic            load;

  // two-flop synchroniser followed by one stage of edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

`ifdef TIMER_IRQ_EN
  localparam int TW =
    (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'(TIMER_PERIOD - 1);

  logic [TW-1:0] tcnt;
  logic          tick;

  assign tick = mask_q[NSRC] && (tcnt == TLAST);

  // free-running period counter, parked at 0 while masked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (!mask_q[NSRC] || tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end
`else
  logic unused_tp;
  assign unused_tp = ^TIMER_PERIOD;
`endif

  // collect all sources that fire this cycle
  always_comb begin
    set_v = '0;
    set_v[NSRC-1:0] = rise;
`ifdef TIMER_IRQ_EN
    set_v[NSRC] = tick;
`endif
  end

  // acknowledged source is retired from pending
  always_comb begin
    clr_v = '0;
    if (state == REQ && int_ack) begin
      clr_v[int_id] = 1'b1;
    end
  end

  // pending flags: a new event beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_v) | set_v;
    end
  end

  // software mask, unimplemented bits forced to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else if (we_mask) begin
      mask_q <= mask_in & SRC_MASK;
    end
  end

  assign req_v = pend_q & mask_q;

  // lowest enabled pending index wins
  always_comb begin
    sel_id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req_v[i]) begin
        sel_id = 3'(i);
      end
    end
  end

  assign sel_vec = PC_W'(
    32'(VEC_BASE) +
    32'(sel_id) * 32'(VEC_STRIDE));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // one interrupt in flight at a time
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_v) begin
          state_n = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_n = SERVICE;
        end
      end
      SERVICE: begin
        if (s_finish_interr) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // id and vector frozen from the IDLE decision onward
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_id     <= '0;
      int_vector <= '0;
    end else if (load) begin
      int_id     <= sel_id;
      int_vector <= sel_vec;
    end
  end

  assign s_interruption = (state == REQ);
  assign busy           = (state != IDLE);
  assign pending        = pend_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed vectors for intr_ctrl.
// Timer checks compile only with TIMER_IRQ_EN.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       we_mask;
  logic [7:0] mask_in;
  logic       int_ack;
  logic       fin;
  logic       s_int;
  logic [9:0] int_vector;
  logic [2:0] int_id;
  logic [7:0] pending;
  logic       busy;

  int nvec = 0;
  int nerr = 0;

  intr_ctrl #(
    .NSRC(4),
    .PC_W(10),
    .VEC_BASE(10'h3C0),
    .VEC_STRIDE(8),
    .TIMER_PERIOD(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .we_mask(we_mask),
    .mask_in(mask_in),
    .int_ack(int_ack),
    .s_finish_interr(fin),
    .s_interruption(s_int),
    .int_vector(int_vector),
    .int_id(int_id),
    .pending(pending),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wr_mask(input logic [7:0] m);
    mask_in = m;
    we_mask = 1'b1;
    tick();
    we_mask = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic fnsh();
    fin = 1'b1;
    tick();
    fin = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    irq_in  = '0;
    we_mask = 1'b0;
    mask_in = '0;
    int_ack = 1'b0;
    fin     = 1'b0;
    #12;
    check("rst_sint", s_int, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pending, 0);
    check("rst_id", int_id, 0);
    check("rst_vec", int_vector, 0);
    reset = 1'b0;
    tick();
    wr_mask(8'h0F);

    // single source 2
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    tick();
    tick();
    check("t1_pend", pending, 8'h04);
    check("t1_sint0", s_int, 0);
    tick();
    check("t1_sint", s_int, 1);
    check("t1_id", int_id, 2);
    check("t1_vec", int_vector, 10'h3D0);
    check("t1_busy", busy, 1);
    fnsh();
    check("t1_fin_ign", s_int, 1);
    ack();
    check("t1_ack_sint", s_int, 0);
    check("t1_ack_busy", busy, 1);
    check("t1_ack_pend", pending, 0);
    fnsh();
    check("t1_idle", busy, 0);
    ack();
    check("t1_ack_ign", busy, 0);

    // sources 1 and 3 together
    irq_in = 4'b1010;
    tick();
    irq_in = '0;
    tick();
    tick();
    check("t2_pend", pending, 8'h0A);
    tick();
    check("t2_id1", int_id, 1);
    check("t2_vec1", int_vector, 10'h3C8);
    ack();
    check("t2_pend8", pending, 8'h08);
    fnsh();
    check("t2_idle", busy, 0);
    tick();
    check("t2_sint3", s_int, 1);
    check("t2_id3", int_id, 3);
    check("t2_vec3", int_vector, 10'h3D8);
    ack();
    fnsh();
    check("t2_pend0", pending, 0);

    // masked source, then unmask
    wr_mask(8'h00);
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    tick();
    tick();
    check("t3_pend", pending, 8'h01);
    tick();
    tick();
    check("t3_masked", s_int, 0);
    wr_mask(8'h01);
    tick();
    check("t3_unmask", s_int, 1);
    check("t3_id", int_id, 0);
    check("t3_vec", int_vector, 10'h3C0);
    ack();
    fnsh();

    // held level, mask change in REQ
    irq_in = 4'b0001;
    tick();
    tick();
    tick();
    check("t4_pend", pending, 8'h01);
    tick();
    check("t4_req", s_int, 1);
    wr_mask(8'h00);
    check("t4_mask_hold", s_int, 1);
    wr_mask(8'h01);
    tick();
    tick();
    check("t4_hold_id", int_id, 0);
    ack();
    check("t4_no_retrig", pending, 0);
    check("t4_svc", busy, 1);
    irq_in = '0;
    fnsh();
    tick();
    tick();
    tick();
    check("t4_quiet", s_int, 0);
    check("t4_quiet_p", pending, 0);

    // edge coincident with ack
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    tick();
    tick();
    tick();
    check("t4b_req", s_int, 1);
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("t4b_setwin", pending, 8'h01);
    check("t4b_sint", s_int, 0);
    fnsh();
    check("t4b_idle", s_int, 0);
    tick();
    check("t4b_rereq", s_int, 1);
    check("t4b_id", int_id, 0);
    ack();
    fnsh();

    // async reset during SERVICE
    wr_mask(8'h0F);
    irq_in = 4'b1000;
    tick();
    irq_in = '0;
    tick();
    tick();
    tick();
    check("t5_id3", int_id, 3);
    ack();
    irq_in = 4'b0110;
    tick();
    irq_in = '0;
    tick();
    tick();
    check("t5_pend", pending, 8'h06);
    check("t5_busy", busy, 1);
    #3;
    reset = 1'b1;
    #1;
    check("t5_sint", s_int, 0);
    check("t5_rbusy", busy, 0);
    check("t5_rpend", pending, 0);
    check("t5_rid", int_id, 0);
    check("t5_rvec", int_vector, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_after", busy, 0);
    check("t5_after_p", pending, 0);

`ifdef TIMER_IRQ_EN
    wr_mask(8'h10);
    repeat (9) tick();
    check("tm_early", pending, 0);
    tick();
    check("tm_pend", pending, 8'h10);
    tick();
    check("tm_sint", s_int, 1);
    check("tm_id", int_id, 4);
    check("tm_vec", int_vector, 10'h3E0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
